// File: rtl/and2n.sv
// Parameterised n-bit bitwise AND with a live combinational result and a
// registered copy carrying a valid flag plus zero/all-ones/popcount status.
module and2n #(
  parameter int n = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [n-1:0]             A,
  input  logic [n-1:0]             B,
  input  logic                     in_valid,
  output logic [n-1:0]             F,
  output logic [n-1:0]             F_q,
  output logic                     out_valid,
  output logic                     zero_q,
  output logic                     ones_q,
  output logic [$clog2(n+1)-1:0]   popcnt_q
);

  localparam int PW = $clog2(n+1);

  logic [PW-1:0] pop_count;
  logic          is_zero;
  logic          is_ones;

  assign F       = A & B;
  assign is_zero = ~|F;
  assign is_ones = &F;

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < n; i++) begin
      pop_count = pop_count + PW'(F[i]);
    end
  end

  // Status payload only moves on a valid capture; out_valid alone marks staleness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_q       <= '0;
      out_valid <= 1'b0;
      zero_q    <= 1'b0;
      ones_q    <= 1'b0;
      popcnt_q  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        F_q      <= F;
        zero_q   <= is_zero;
        ones_q   <= is_ones;
        popcnt_q <= pop_count;
      end
    end
  end

endmodule

// File: tb/tb_and2n.sv
// Scoreboard bench for and2n at widths 1, 3 and 8 sharing clock and reset.
module tb_and2n;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] a3, b3;
  logic [7:0] a8, b8;
  logic       a1, b1;

  logic [2:0] f3, f3_q;
  logic       ov3, z3, o3;
  logic [1:0] p3;
  logic [7:0] f8, f8_q;
  logic       ov8, z8, o8;
  logic [3:0] p8;
  logic       f1, f1_q, ov1, z1, o1, p1;

  typedef struct {
    logic [2:0] f3;
    logic       z3, o3;
    logic [1:0] p3;
    logic [7:0] f8;
    logic       z8, o8;
    logic [3:0] p8;
    logic       f1, z1, o1, p1;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t zero_exp;

  int checks = 0;
  int errors = 0;

  and2n #(.n(3)) u3 (
    .clk(clk), .rst_n(rst_n), .A(a3), .B(b3), .in_valid(in_valid),
    .F(f3), .F_q(f3_q), .out_valid(ov3), .zero_q(z3), .ones_q(o3), .popcnt_q(p3)
  );

  and2n #(.n(8)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(in_valid),
    .F(f8), .F_q(f8_q), .out_valid(ov8), .zero_q(z8), .ones_q(o8), .popcnt_q(p8)
  );

  and2n #(.n(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(in_valid),
    .F(f1), .F_q(f1_q), .out_valid(ov1), .zero_q(z1), .ones_q(o1), .popcnt_q(p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t buildExpect(input logic [2:0] a, input logic [2:0] b,
                                       input logic [7:0] wa, input logic [7:0] wb,
                                       input logic na, input logic nb);
    exp_t e;
    e.f3 = a & b;
    e.z3 = (e.f3 == 3'b000);
    e.o3 = (e.f3 == 3'b111);
    e.p3 = 2'($countones(e.f3));
    e.f8 = wa & wb;
    e.z8 = (e.f8 == 8'h00);
    e.o8 = (e.f8 == 8'hFF);
    e.p8 = 4'($countones(e.f8));
    e.f1 = na & nb;
    e.z1 = ~e.f1;
    e.o1 = e.f1;
    e.p1 = e.f1;
    return e;
  endfunction

  task automatic checkRegistered(input exp_t e, input logic valid);
    checkOutput("ov3", 64'(ov3), 64'(valid));
    checkOutput("ov8", 64'(ov8), 64'(valid));
    checkOutput("ov1", 64'(ov1), 64'(valid));
    checkOutput("F3_q", 64'(f3_q), 64'(e.f3));
    checkOutput("zero3", 64'(z3), 64'(e.z3));
    checkOutput("ones3", 64'(o3), 64'(e.o3));
    checkOutput("pop3", 64'(p3), 64'(e.p3));
    checkOutput("F8_q", 64'(f8_q), 64'(e.f8));
    checkOutput("zero8", 64'(z8), 64'(e.z8));
    checkOutput("ones8", 64'(o8), 64'(e.o8));
    checkOutput("pop8", 64'(p8), 64'(e.p8));
    checkOutput("F1_q", 64'(f1_q), 64'(e.f1));
    checkOutput("zero1", 64'(z1), 64'(e.z1));
    checkOutput("ones1", 64'(o1), 64'(e.o1));
    checkOutput("pop1", 64'(p1), 64'(e.p1));
    if (valid) checkOutput("n1_flags_compl", 64'(z1 ^ o1), 64'd1);
  endtask

  // Drive operands mid-cycle, check the live AND, then check the captured state.
  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                               input logic [7:0] wa, input logic [7:0] wb,
                               input logic valid);
    exp_t e;
    a3 = a; b3 = b; a8 = wa; b8 = wb; a1 = a[0]; b1 = b[0];
    in_valid = valid;
    e = buildExpect(a, b, wa, wb, a[0], b[0]);
    #1;
    checkOutput("F3", 64'(f3), 64'(e.f3));
    checkOutput("F8", 64'(f8), 64'(e.f8));
    checkOutput("F1", 64'(f1), 64'(e.f1));
    if (valid) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    checkRegistered(last_exp, valid);
  endtask

  initial begin
    zero_exp = buildExpect(3'b000, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    zero_exp.z3 = 1'b0; zero_exp.z8 = 1'b0; zero_exp.z1 = 1'b0;
    last_exp = zero_exp;
    rst_n = 1'b0; in_valid = 1'b0;
    a3 = '0; b3 = '0; a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
    #1;
    checkRegistered(zero_exp, 1'b0);

    // Combinational checks during reset, including truncated operands.
    a3 = 3'b000; b3 = 3'b000; #1; checkOutput("comb_0_0", 64'(f3), 64'b000);
    a3 = 3'(4'd11); b3 = 3'b001; #1; checkOutput("comb_11_01", 64'(f3), 64'b001);
    a3 = 3'(4'd10); b3 = 3'b001; #1; checkOutput("comb_10_01", 64'(f3), 64'b000);
    a3 = 3'(4'd11); b3 = 3'(4'd11); #1; checkOutput("comb_11_11", 64'(f3), 64'b011);
    @(posedge clk); #1;
    checkRegistered(zero_exp, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b111, 3'b101, 8'hF0, 8'h3C, 1'b1);
    checkOutput("plan_F3_q", 64'(f3_q), 64'b101);
    checkOutput("plan_pop3", 64'(p3), 64'd2);
    checkOutput("plan_F8_q", 64'(f8_q), 64'h30);
    checkOutput("plan_pop8", 64'(p8), 64'd2);
    applyStimulus(3'b111, 3'b111, 8'hFF, 8'hFF, 1'b1);
    checkOutput("plan_ones3", 64'(o3), 64'd1);
    applyStimulus(3'b101, 3'b010, 8'hAA, 8'h55, 1'b1);
    checkOutput("plan_zero3", 64'(z3), 64'd1);

    // Hold: payload stays while live operands keep changing.
    applyStimulus(3'b110, 3'b111, 8'h81, 8'hC3, 1'b1);
    applyStimulus(3'b011, 3'b001, 8'h12, 8'hFF, 1'b0);
    applyStimulus(3'b111, 3'b111, 8'hFF, 8'h0F, 1'b0);
    applyStimulus(3'b000, 3'b101, 8'h00, 8'hFF, 1'b0);
    checkOutput("hold_F3_q", 64'(f3_q), 64'b110);

    // Back-to-back random captures.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-cycle while out_valid is high.
    applyStimulus(3'b111, 3'b011, 8'h7E, 8'hE7, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    last_exp = zero_exp;
    checkRegistered(zero_exp, 1'b0);
    a3 = 3'b101; b3 = 3'b100; #1;
    checkOutput("comb_in_reset", 64'(f3), 64'b100);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b110, 3'b011, 8'h0F, 8'hF1, 1'b1);
    checkOutput("post_reset_F3_q", 64'(f3_q), 64'b010);
    applyStimulus(3'b000, 3'b000, 8'h00, 8'h00, 1'b1);
    applyStimulus(3'b001, 3'b001, 8'h01, 8'h01, 1'b1);

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/and2n.md
Name: and2n

Overview:
- Parameterised n-bit bitwise 2-input AND unit used as a building block in the carry-lookahead/ALU datapath.
- Provides a purely combinational result F with zero latency.
- Also provides a registered copy with a valid flag, plus reduction flags (zero, all-ones, population count) for downstream status logic.

Parameters:
- n, default 4: operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered outputs only.
- rst_n  input  1  asynchronous active-low reset.
- A  input  n  operand A.
- B  input  n  operand B.
- in_valid  input  1  qualifies A/B for capture into the output register.
- F  output  n  combinational result, A & B bitwise.
- F_q  output  n  registered result.
- out_valid  output  1  F_q holds a result captured in the previous cycle.
- zero_q  output  1  registered flag, set when the captured result is all zeros.
- ones_q  output  1  registered flag, set when the captured result is all ones.
- popcnt_q  output  clog2(n+1)  registered count of 1 bits in the captured result.

Behaviour:
- F[i] = A[i] & B[i] for every i in 0..n-1.
  - Purely combinational: no clock, reset or in_valid dependence.
  - F settles within the same time step as any A/B change.
- Operands wider than n driven by the parent are truncated to the low n bits by normal port connection. Examples for n=3: decimal 11 becomes 3'b011; decimal 10 becomes 3'b010.
- While rst_n=0 (asynchronous, takes effect immediately regardless of clk), all registered outputs are held at:
  - F_q=0, out_valid=0, zero_q=0, ones_q=0, popcnt_q=0.
- Release of rst_n takes effect at the next rising clk edge; no capture happens on the edge coincident with release while rst_n is still low.
- Rising clk edge with in_valid=1 (one-cycle latency from A/B to F_q):
  - F_q <= A & B
  - out_valid <= 1
  - zero_q <= (A & B) == 0
  - ones_q <= (A & B) == all ones
  - popcnt_q <= number of set bits in (A & B)
- Rising clk edge with in_valid=0:
  - out_valid <= 0.
  - F_q, zero_q, ones_q and popcnt_q hold their previous values; only out_valid marks them as stale.
- Back-to-back in_valid=1 captures every cycle; there is no backpressure and no stall input.
- Reset asserted mid-stream clears all registered state immediately; F continues to follow A & B.
- n=1 boundary:
  - zero_q and ones_q are complementary whenever out_valid=1.
  - popcnt_q is 1 bit wide.
- X/Z on an input bit propagates per standard AND semantics: a 0 on either input forces a 0 result bit.

Test Plan:
- n=3, combinational: apply A=0, B=0 and check 1 time unit later -> F=000. Apply A=11 (decimal), B=01 -> F=001. Apply A=10, B=01 -> F=000. Apply A=11, B=11 -> F=011.
- n=3, registered: pulse in_valid=1 with A=3'b111, B=3'b101 -> next edge gives F_q=101, out_valid=1, popcnt_q=2, zero_q=0, ones_q=0.
- n=3 boundary flags: capture A=111, B=111 -> ones_q=1, popcnt_q=3. Then capture A=101, B=010 -> zero_q=1, popcnt_q=0.
- Hold behaviour: capture a value, then in_valid=0 for 3 cycles -> out_valid=0 and F_q unchanged; F still tracks live A & B.
- Asynchronous reset: assert rst_n=0 between clock edges while out_valid=1 -> all registered outputs go to 0 immediately. Release, then capture A=110, B=011 -> F_q=010 on the first edge after release.
- n=8 default-style width: A=8'hF0, B=8'h3C -> F=8'h30; after capture, popcnt_q=2.
